mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle sequencer for the RV32M multiply/divide unit in the EXE stage.
- Latches operands from ID/EX and drives them, held stable, into the combinational multiplier for MUL_LAT cycles. The multiplier has a long propagation delay, so this is a multi-cycle path. The sequencer then captures the product.
- Executes DIV/DIVU/REM/REMU with an internal 32-iteration restoring divider.
- Asserts busy to stall the pipeline and returns a single registered result with a one-cycle valid pulse to the EX/MEM path.

Parameters:
- MUL_LAT, 2: clock cycles the multiplier operands are held before the product is sampled (≥1).
- XLEN, 32: operand/result width (only 32 is supported).

Ports:
- clk  in  1  Clock; all state updates on the rising edge.
- rst_n  in  1  Asynchronous active-low reset.
- mdu_start  in  1  Request; sampled only when the block is not busy.
- mdu_funct3  in  3  M-ext funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- mdu_opra  in  32  rs1 value.
- mdu_oprb  in  32  rs2 value.
- mdu_flush  in  1  Pipeline flush; aborts any operation in flight.
- mul_opra  out  32  Registered operand A to the multiplier.
- mul_oprb  out  32  Registered operand B to the multiplier.
- mul_funct3  out  3  Registered funct3 to the multiplier, passed unchanged.
- mul_result  in  32  Combinational product from the multiplier.
- mdu_busy  out  1  High in MUL_WAIT and DIV_RUN; pipeline stall request.
- mdu_valid  out  1  One-cycle pulse; mdu_result is valid.
- mdu_result  out  32  Registered result; held until the next completion.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=IDLE.
  - mdu_busy=0, mdu_valid=0.
  - mdu_result, mul_opra, mul_oprb, mul_funct3 = 0.
  - Counter=0; divider registers=0.
  - Reset mid-operation discards the operation; no valid is produced.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- IDLE or DONE, at edge E0 with mdu_start=1 and mdu_flush=0:
  - Latch operands and funct3.
  - funct3[2]=0 → MUL_WAIT, counter=MUL_LAT-1.
  - funct3[2]=1 → DIV_RUN, or DONE directly for a special case.
  - DONE accepts a new start in the same cycle, so back-to-back operations are supported.
- MUL_WAIT:
  - mul_* outputs stay constant.
  - Counter decrements each edge.
  - At edge E_MUL_LAT (counter==0): mdu_result ← mul_result; go to DONE.
  - mdu_valid is high during the cycle after E_MUL_LAT.
  - MUL latency = MUL_LAT cycles to valid.
- DIV_RUN:
  - Setup at E0:
    - Signed ops (DIV/REM) take magnitudes of the operands; record sign(q)=sa^sb and sign(r)=sa.
    - Unsigned ops use the operands as-is.
  - One restoring step per edge, E1..E32: shift {rem,quo} left; trial-subtract the divisor; set the quotient bit if the result is non-negative.
  - At E33: apply sign correction (two's complement); select quotient (DIV/DIVU) or remainder (REM/REMU) into mdu_result; go to DONE.
  - Valid is high in the cycle after E33.
- Special cases, detected at E0; DONE at E1, valid in the cycle after E1:
  - Divide by zero: quotient=0xFFFFFFFF; remainder=dividend.
  - Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM only): quotient=0x80000000; remainder=0.
- DONE:
  - mdu_valid=1 for exactly one cycle.
  - Next state is IDLE, or a new operation if mdu_start=1.
- Flush:
  - mdu_flush=1 forces IDLE at the next edge from any state.
  - No valid is produced.
  - Flush has priority over a simultaneous start, which is dropped.
  - mdu_result keeps its previous value.
- mdu_start while busy is ignored. The upstream stage must hold the instruction while mdu_busy=1.
- mul_* outputs change only at an accepted start. They hold their value in every other state.

Test Plan:
- MUL_LAT=2; start MUL 7×6 (funct3=000) → mdu_busy high for 2 cycles; mdu_valid pulses exactly 2 cycles after the start edge; mdu_result=42; mul_opra/mul_oprb stable throughout.
- DIV: 0xFFFFFFF9 (-7) / 2 → valid 33 cycles after start; result 0xFFFFFFFD (-3). Same operands as REM → 0xFFFFFFFF (-1).
- DIVU 100/0 → result 0xFFFFFFFF at valid 1 cycle after start. REMU 100/0 → 100.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000. REM of the same → 0; valid 1 cycle after start.
- Start DIVU 1000/7, then assert mdu_flush at cycle 10 → IDLE next edge; no valid; mdu_result unchanged. A new MULHU 0xFFFFFFFF×0xFFFFFFFF started next → 0xFFFFFFFE.
- rst_n pulled low mid-DIV_RUN (asynchronous, between edges) → busy=0, valid=0, result=0 immediately. mdu_start asserted during busy is ignored (no second valid).

Source files
------------

// File: rtl/mdu_seq.sv
// Multi-cycle sequencer for the RV32M multiply/divide unit.
// Holds multiplier operands stable across a multi-cycle path, then samples
// the product. Divides with a 32-step restoring divider. Raises busy while
// working and reports one registered result with a single-cycle valid pulse.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for mdu_start
// MUL_WAIT | operands held on mul_*, counting down the multiplier delay
// DIV_RUN  | restoring divide steps, then sign fix-up and result select
// DONE     | mdu_valid high for one cycle; may accept a new start
module mdu_seq #(
   parameter int MUL_LAT = 2,
   parameter int XLEN    = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            mdu_start,
   input  logic [2:0]      mdu_funct3,
   input  logic [XLEN-1:0] mdu_opra,
   input  logic [XLEN-1:0] mdu_oprb,
   input  logic            mdu_flush,
   output logic [XLEN-1:0] mul_opra,
   output logic [XLEN-1:0] mul_oprb,
   output logic [2:0]      mul_funct3,
   input  logic [XLEN-1:0] mul_result,
   output logic            mdu_busy,
   output logic            mdu_valid,
   output logic [XLEN-1:0] mdu_result
);

   localparam int                CNT_W        = 6;
   localparam logic [CNT_W-1:0]  MUL_CNT_INIT = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0]  DIV_CNT_INIT = CNT_W'(XLEN);
   localparam logic [XLEN-1:0]   ALL_ONES     = {XLEN{1'b1}};
   localparam logic [XLEN-1:0]   INT_MIN      = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MUL_WAIT = 2'd1,
      DIV_RUN  = 2'd2,
      DONE     = 2'd3
   } state_t;

   state_t            state, state_nxt;
   logic              start_ok;
   logic [CNT_W-1:0]  cnt;

   logic [XLEN-1:0]   div_rem;
   logic [XLEN-1:0]   div_quo;
   logic [XLEN-1:0]   div_dvsr;
   logic              neg_quo;
   logic              neg_rem;
   logic              sel_rem;

   logic              is_signed;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   abs_a;
   logic [XLEN-1:0]   abs_b;
   logic              div_zero;
   logic              div_ovf;
   logic [XLEN:0]     shl;
   logic [XLEN:0]     diff;
   logic [XLEN-1:0]   quo_fix;
   logic [XLEN-1:0]   rem_fix;

   // DIV/REM are signed (funct3[0]=0); DIVU/REMU are unsigned.
   assign is_signed = ~mdu_funct3[0];
   assign a_neg     = is_signed & mdu_opra[XLEN-1];
   assign b_neg     = is_signed & mdu_oprb[XLEN-1];
   assign abs_a     = a_neg ? -mdu_opra : mdu_opra;
   assign abs_b     = b_neg ? -mdu_oprb : mdu_oprb;
   assign div_zero  = (mdu_oprb == '0);
   assign div_ovf   = is_signed & (mdu_opra == INT_MIN) & (mdu_oprb == ALL_ONES);

   // One restoring step: remainder stays below the divisor, so the shifted
   // value fits in XLEN+1 bits and the trial difference sign is bit XLEN.
   assign shl     = {div_rem, div_quo[XLEN-1]};
   assign diff    = shl - {1'b0, div_dvsr};
   assign quo_fix = neg_quo ? -div_quo : div_quo;
   assign rem_fix = neg_rem ? -div_rem : div_rem;

   assign mdu_busy  = (state == MUL_WAIT) || (state == DIV_RUN);
   assign mdu_valid = (state == DONE);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; flush overrides everything including a start.
   always_comb begin
      state_nxt = state;
      start_ok  = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (mdu_start) begin
               start_ok  = 1'b1;
               state_nxt = mdu_funct3[2] ? DIV_RUN : MUL_WAIT;
            end else begin
               state_nxt = IDLE;
            end
         end
         MUL_WAIT: if (cnt == '0) state_nxt = DONE;
         DIV_RUN:  if (cnt == '0) state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
      if (mdu_flush) begin
         state_nxt = IDLE;
         start_ok  = 1'b0;
      end
   end

   // Operand capture, cycle counter, divider datapath and result register.
   // Special divides preload quotient/remainder with the final answer and a
   // zero count, so they finish through the normal fix-up one edge later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mul_opra   <= '0;
         mul_oprb   <= '0;
         mul_funct3 <= '0;
         mdu_result <= '0;
         cnt        <= '0;
         div_rem    <= '0;
         div_quo    <= '0;
         div_dvsr   <= '0;
         neg_quo    <= 1'b0;
         neg_rem    <= 1'b0;
         sel_rem    <= 1'b0;
      end else if (!mdu_flush) begin
         if (start_ok) begin
            mul_opra   <= mdu_opra;
            mul_oprb   <= mdu_oprb;
            mul_funct3 <= mdu_funct3;
            if (mdu_funct3[2]) begin
               sel_rem  <= mdu_funct3[1];
               div_dvsr <= abs_b;
               if (div_zero) begin
                  div_quo <= ALL_ONES;
                  div_rem <= mdu_opra;
                  neg_quo <= 1'b0;
                  neg_rem <= 1'b0;
                  cnt     <= '0;
               end else if (div_ovf) begin
                  div_quo <= INT_MIN;
                  div_rem <= '0;
                  neg_quo <= 1'b0;
                  neg_rem <= 1'b0;
                  cnt     <= '0;
               end else begin
                  div_quo <= abs_a;
                  div_rem <= '0;
                  neg_quo <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  cnt     <= DIV_CNT_INIT;
               end
            end else begin
               cnt <= MUL_CNT_INIT;
            end
         end else if (state == MUL_WAIT) begin
            if (cnt == '0) mdu_result <= mul_result;
            else           cnt        <= cnt - 1'b1;
         end else if (state == DIV_RUN) begin
            if (cnt == '0) begin
               mdu_result <= sel_rem ? rem_fix : quo_fix;
            end else begin
               if (!diff[XLEN]) begin
                  div_rem <= diff[XLEN-1:0];
                  div_quo <= {div_quo[XLEN-2:0], 1'b1};
               end else begin
                  div_rem <= shl[XLEN-1:0];
                  div_quo <= {div_quo[XLEN-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural multiplier on the mul_* path.
module tb_mdu_seq;

   logic        clk;
   logic        rst_n;
   logic        mdu_start;
   logic [2:0]  mdu_funct3;
   logic [31:0] mdu_opra;
   logic [31:0] mdu_oprb;
   logic        mdu_flush;
   logic [31:0] mul_opra;
   logic [31:0] mul_oprb;
   logic [2:0]  mul_funct3;
   logic [31:0] mul_result;
   logic        mdu_busy;
   logic        mdu_valid;
   logic [31:0] mdu_result;

   int n_tests = 0;
   int n_fail  = 0;

   mdu_seq #(.MUL_LAT(2), .XLEN(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mdu_start  (mdu_start),
      .mdu_funct3 (mdu_funct3),
      .mdu_opra   (mdu_opra),
      .mdu_oprb   (mdu_oprb),
      .mdu_flush  (mdu_flush),
      .mul_opra   (mul_opra),
      .mul_oprb   (mul_oprb),
      .mul_funct3 (mul_funct3),
      .mul_result (mul_result),
      .mdu_busy   (mdu_busy),
      .mdu_valid  (mdu_valid),
      .mdu_result (mdu_result)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RV32M multiplier.
   logic [63:0] p_ss, p_su, p_uu;
   assign p_ss = $signed({{32{mul_opra[31]}}, mul_opra}) * $signed({{32{mul_oprb[31]}}, mul_oprb});
   assign p_su = $signed({{32{mul_opra[31]}}, mul_opra}) * $signed({32'b0, mul_oprb});
   assign p_uu = {32'b0, mul_opra} * {32'b0, mul_oprb};
   always_comb begin
      mul_result = p_uu[31:0];
      case (mul_funct3[1:0])
         2'b01:   mul_result = p_ss[63:32];
         2'b10:   mul_result = p_su[63:32];
         2'b11:   mul_result = p_uu[63:32];
         default: mul_result = p_uu[31:0];
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic start_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      mdu_start  = 1'b1;
      mdu_funct3 = f3;
      mdu_opra   = a;
      mdu_oprb   = b;
      @(posedge clk);
      #1;
      mdu_start = 1'b0;
   endtask

   // Runs one operation, measuring latency (cycles from start edge to the
   // cycle valid is high), busy duration, mul_* stability and pulse width.
   task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int n;
      int busy_cnt;
      int unstable;
      bit seen;
      n = 0; busy_cnt = 0; unstable = 0; seen = 0;
      start_op(f3, a, b);
      while (n < 45 && !seen) begin
         @(negedge clk);
         n++;
         if (mul_opra !== a || mul_oprb !== b) unstable++;
         if (mdu_valid) seen = 1;
         else if (mdu_busy) busy_cnt++;
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_lat"},    32'(n - 1), 32'(exp_lat));
         chk({tag, "_result"}, mdu_result, exp_res);
         chk({tag, "_busy"},   32'(busy_cnt), 32'(exp_lat));
         chk({tag, "_stable"}, 32'(unstable), 32'd0);
         @(negedge clk);
         chk({tag, "_pulse"},  {31'b0, mdu_valid}, 32'd0);
      end
   endtask

   initial begin
      int nv;
      mdu_start  = 1'b0;
      mdu_funct3 = 3'b000;
      mdu_opra   = '0;
      mdu_oprb   = '0;
      mdu_flush  = 1'b0;
      rst_n      = 1'b0;
      #23;
      chk("rst_busy",   {31'b0, mdu_busy},  32'd0);
      chk("rst_valid",  {31'b0, mdu_valid}, 32'd0);
      chk("rst_result", mdu_result, 32'd0);
      chk("rst_opra",   mul_opra,   32'd0);
      chk("rst_oprb",   mul_oprb,   32'd0);
      chk("rst_funct3", {29'b0, mul_funct3}, 32'd0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        32'd42,       2);
      run_op("mulh_m2x3",    3'b001, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 2);
      run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
      run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
      run_op("divu_100_0",   3'b101, 32'd100,      32'd0,        32'hFFFFFFFF, 1);
      run_op("remu_100_0",   3'b111, 32'd100,      32'd0,        32'd100,      1);
      run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
      run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
      run_op("divu_1000_7",  3'b101, 32'd1000,     32'd7,        32'd142,      33);
      run_op("remu_1000_7",  3'b111, 32'd1000,     32'd7,        32'd6,        33);

      // Flush mid-divide: no valid, result keeps the previous value (6).
      start_op(3'b101, 32'd1000, 32'd7);
      repeat (9) @(negedge clk);
      mdu_flush = 1'b1;
      @(posedge clk);
      #1;
      mdu_flush = 1'b0;
      chk("flush_busy", {31'b0, mdu_busy}, 32'd0);
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (mdu_valid) nv++;
      end
      chk("flush_novalid", 32'(nv), 32'd0);
      chk("flush_result",  mdu_result, 32'd6);
      run_op("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);

      // Start while busy is ignored: exactly one valid, result of the divide.
      start_op(3'b100, 32'hFFFFFFF9, 32'd2);
      repeat (2) @(negedge clk);
      mdu_start  = 1'b1;
      mdu_funct3 = 3'b000;
      mdu_opra   = 32'd3;
      mdu_oprb   = 32'd3;
      repeat (3) @(negedge clk);
      mdu_start = 1'b0;
      chk("busy_start_opra", mul_opra, 32'hFFFFFFF9);
      nv = 0;
      repeat (45) begin
         @(negedge clk);
         if (mdu_valid) nv++;
      end
      chk("busy_start_nvalid", 32'(nv), 32'd1);
      chk("busy_start_result", mdu_result, 32'hFFFFFFFD);

      // Asynchronous reset in the middle of a divide.
      start_op(3'b101, 32'd1000, 32'd7);
      repeat (10) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy",   {31'b0, mdu_busy},  32'd0);
      chk("arst_valid",  {31'b0, mdu_valid}, 32'd0);
      chk("arst_result", mdu_result, 32'd0);
      chk("arst_opra",   mul_opra,   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      nv = 0;
      repeat (40) begin
         @(negedge clk);
         if (mdu_valid) nv++;
      end
      chk("arst_novalid", 32'(nv), 32'd0);
      run_op("mul_after_rst", 3'b000, 32'd7, 32'd6, 32'd42, 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
